// File: rtl/lsmitll_ptltx_arbiter.sv
// Round-robin arbiter that shares one edge-encoded PTL TX input among N_REQ pulse sources,
// enforcing startup blackout and minimum toggle spacing. Optional check: PTLTX_LOOPBACK_CHECK_EN.
module lsmitll_ptltx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int CNT_W          = 4,
  parameter int MIN_GAP        = 4,
  parameter int STARTUP_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
`ifdef PTLTX_LOOPBACK_CHECK_EN
  input  logic                       rx_q,
  output logic                       loop_err,
`endif
  output logic [N_REQ-1:0]           pend_full,
  output logic [N_REQ-1:0]           ovf,
  output logic                       tx_a,
  output logic                       tx_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       idle
);

  localparam int GW = $clog2(N_REQ);
  localparam int SW = $clog2(STARTUP_CYCLES + 2);
  localparam int PW = $clog2(MIN_GAP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_STARTUP, ST_READY, ST_GAP} state_t;

  state_t           state_q;
  logic [SW-1:0]    su_q;
  logic [PW-1:0]    gap_q;
  logic             tx_a_q;
  logic             tx_valid_q;
  logic [GW-1:0]    grant_q;

  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [N_REQ-1:0] ovf_q;
  logic [N_REQ-1:0] ovf_d;

  logic             sel_vld;
  logic [GW-1:0]    sel_idx;
  logic             emit;

  // Search starts one past the last grant so continuously pending sources rotate strictly.
  always_comb begin : rr_search
    logic [GW:0] cand;
    cand    = '0;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, grant_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_REQ)) cand = cand - (GW+1)'(N_REQ);
      if (!sel_vld && (cnt_q[cand[GW-1:0]] != '0)) begin
        sel_vld = 1'b1;
        sel_idx = cand[GW-1:0];
      end
    end
  end

  assign emit = (state_q == ST_READY) && sel_vld;

  // A grant and a request on the same source cancel, so a full counter never overflows then.
  always_comb begin : cnt_next
    logic gnt;
    gnt   = 1'b0;
    ovf_d = ovf_q;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      gnt      = emit && (sel_idx == GW'(i));
      if (req[i] && !gnt) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!req[i] && gnt) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STARTUP;
      su_q       <= SW'(STARTUP_CYCLES);
      gap_q      <= '0;
      tx_a_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      grant_q    <= GW'(N_REQ - 1);
    end else begin
      tx_valid_q <= 1'b0;
      case (state_q)
        ST_STARTUP: begin
          if (su_q <= SW'(1)) state_q <= ST_READY;
          if (su_q != '0)     su_q    <= su_q - SW'(1);
        end
        ST_READY: begin
          if (emit) begin
            tx_a_q     <= ~tx_a_q;
            tx_valid_q <= 1'b1;
            grant_q    <= sel_idx;
            if (MIN_GAP > 1) begin
              state_q <= ST_GAP;
              gap_q   <= PW'(MIN_GAP - 1);
            end
          end
        end
        ST_GAP: begin
          if (gap_q <= PW'(1)) state_q <= ST_READY;
          if (gap_q != '0)     gap_q   <= gap_q - PW'(1);
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  always_comb begin
    idle = (state_q == ST_READY);
    for (int i = 0; i < N_REQ; i++) begin
      pend_full[i] = (cnt_q[i] == CNT_MAX);
      if (cnt_q[i] != '0) idle = 1'b0;
    end
  end

  assign tx_a     = tx_a_q;
  assign tx_valid = tx_valid_q;
  assign grant_id = grant_q;
  assign ovf      = ovf_q;

`ifdef PTLTX_LOOPBACK_CHECK_EN
  logic          rx_prev_q;
  logic          armed_q;
  logic [PW-1:0] win_q;
  logic          loop_err_q;
  logic          rx_tog;

  assign rx_tog = rx_q ^ rx_prev_q;

  // Each emission arms a MIN_GAP-cycle window in which the echoed edge must arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
      win_q      <= '0;
      loop_err_q <= 1'b0;
    end else begin
      rx_prev_q <= rx_q;
      if (armed_q) begin
        if (rx_tog) begin
          armed_q <= 1'b0;
        end else if (win_q == PW'(1)) begin
          armed_q    <= 1'b0;
          loop_err_q <= 1'b1;
        end else begin
          win_q <= win_q - PW'(1);
        end
      end else if (rx_tog) begin
        loop_err_q <= 1'b1;
      end
      if (emit) begin
        armed_q <= 1'b1;
        win_q   <= PW'(MIN_GAP);
      end
    end
  end

  assign loop_err = loop_err_q;
`endif

endmodule

// File: tb/tb_lsmitll_ptltx_arbiter.sv
// Self-checking bench for lsmitll_ptltx_arbiter: randomized requests against a cycle-count
// reference model, plus directed scenarios with literal expectations.
module tb_lsmitll_ptltx_arbiter;
  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int MG   = 4;
  localparam int SC   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] pend_full, ovf;
  logic tx_a, tx_valid, idle;
  logic [$clog2(N)-1:0] grant_id;

`ifdef PTLTX_LOOPBACK_CHECK_EN
  logic rx_q = 1'b0;
  logic rx_d1 = 1'b0;
  logic drop = 1'b0;
  logic loop_err;
`endif

  always #5 clk = ~clk;

  lsmitll_ptltx_arbiter #(.N_REQ(N), .CNT_W(CW), .MIN_GAP(MG), .STARTUP_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .req(req),
`ifdef PTLTX_LOOPBACK_CHECK_EN
    .rx_q(rx_q), .loop_err(loop_err),
`endif
    .pend_full(pend_full), .ovf(ovf), .tx_a(tx_a), .tx_valid(tx_valid),
    .grant_id(grant_id), .idle(idle)
  );

`ifdef PTLTX_LOOPBACK_CHECK_EN
  // Receiver echo: tx_a delayed by two cycles, frozen once 'drop' is set.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_d1 <= 1'b0;
      rx_q  <= 1'b0;
    end else begin
      rx_d1 <= tx_a;
      if (!drop) rx_q <= rx_d1;
    end
  end
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: pending counts, last emission cycle, cycles since reset release.
  int m_cnt [N];
  bit m_ovf [N];
  bit m_txa, m_txv;
  int m_gid, m_cyc, m_last;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
    m_txa = 0; m_txv = 0; m_gid = N - 1; m_cyc = 0; m_last = -1000;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int sel;
    sel = -1;
    if (m_cyc >= SC && m_cyc - m_last >= MG)
      for (int k = 1; k <= N; k++)
        if (sel < 0 && m_cnt[(m_gid + k) % N] > 0) sel = (m_gid + k) % N;
    m_txv = (sel >= 0);
    if (sel >= 0) begin m_txa = ~m_txa; m_gid = sel; m_last = m_cyc; end
    for (int i = 0; i < N; i++) begin
      if (r[i] && i != sel) begin
        if (m_cnt[i] == MAXC) m_ovf[i] = 1; else m_cnt[i]++;
      end else if (!r[i] && i == sel) begin
        m_cnt[i]--;
      end
    end
    m_cyc++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int pf, ov;
    bit id;
    pf = 0; ov = 0;
    id = (m_cyc >= SC) && (m_cyc - m_last >= MG);
    for (int i = 0; i < N; i++) begin
      if (m_cnt[i] == MAXC) pf |= (1 << i);
      if (m_ovf[i]) ov |= (1 << i);
      if (m_cnt[i] != 0) id = 0;
    end
    chk("tx_a", int'(tx_a), int'(m_txa));
    chk("tx_valid", int'(tx_valid), int'(m_txv));
    chk("grant_id", int'(grant_id), m_gid);
    chk("pend_full", int'(pend_full), pf);
    chk("ovf", int'(ovf), ov);
    chk("idle", int'(idle), int'(id));
  endtask

  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      if (idle) break;
      step('0);
    end
    chk("idle_reached", int'(idle), 1);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 chk("rst_tx_a", int'(tx_a), 0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ng, ntx;
    int tcyc [4];
    int gids [4];
    logic [N-1:0] r;
    int burst_left, burst_bit;

    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_grant_id", int'(grant_id), N - 1);
    chk("rst_idle", int'(idle), 0);
    rst = 1'b0;

    // Startup blackout: request at cycle 2, first toggle at cycle 8
    for (int c = 0; c < 8; c++) step((c == 2) ? 4'b0001 : 4'b0000);
    chk("t1_no_early_toggle", int'(tx_a), 0);
    step('0);
    chk("t1_toggle_c8", int'(tx_a), 1);
    chk("t1_grant0", int'(grant_id), 0);
    wait_idle();

    // Round robin from grant_id=3: grants 0,1,2,3 spaced MIN_GAP apart
    step(4'b1000);
    wait_idle();
    step(4'b1111);
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      step('0);
      if (tx_valid) begin tcyc[ng] = m_cyc; gids[ng] = int'(grant_id); ng++; end
    end
    chk("t2_count", ng, 4);
    for (int k = 0; k < ng; k++) begin
      chk("t2_gid", gids[k], k);
      chk("t2_spacing", tcyc[k] - tcyc[0], 4 * k);
    end
    wait_idle();

    // Saturation: req[2] held 22 cycles -> 6 emitted, 15 queued, overflow sticky
    ntx = 0;
    for (int c = 0; c < 22; c++) begin
      step(4'b0100);
      ntx += int'(tx_valid);
    end
    chk("t3_pend_full", int'(pend_full[2]), 1);
    chk("t3_ovf", int'(ovf[2]), 1);
    for (int c = 0; c < 300; c++) begin
      if (idle) break;
      step('0);
      ntx += int'(tx_valid);
    end
    chk("t3_total_tx", ntx, 21);
    chk("t3_ovf_sticky", int'(ovf[2]), 1);
    chk("t3_idle", int'(idle), 1);

    // Reset in GAP right after a 0->1 toggle with pulses still queued
    for (int c = 0; c < 40; c++) begin
      step((c < 6) ? 4'b0001 : 4'b0000);
      if (tx_valid && tx_a) break;
    end
    chk("t5_tx_a_high", int'(tx_a), 1);
    async_reset();
    ntx = 0;
    for (int c = 0; c < 28; c++) begin
      step('0);
      ntx += int'(tx_valid);
    end
    chk("t5_no_tx", ntx, 0);
    chk("t5_idle", int'(idle), 1);

    // Randomized traffic with occasional saturating bursts and resets
    burst_left = 0; burst_bit = 0;
    for (int c = 0; c < 3000; c++) begin
      if (burst_left == 0 && $urandom_range(0, 199) == 0) begin
        burst_left = $urandom_range(10, 30);
        burst_bit = $urandom_range(0, N - 1);
      end
      for (int b = 0; b < N; b++)
        r[b] = ($urandom_range(0, 5) == 0) || (burst_left > 0 && b == burst_bit);
      if (burst_left > 0) burst_left--;
      step(r);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

`ifdef PTLTX_LOOPBACK_CHECK_EN
    async_reset();
    for (int c = 0; c < 10; c++) step('0);
    step(4'b0011);
    for (int c = 0; c < 20; c++) step('0);
    chk("lb_echo_ok", int'(loop_err), 0);
    drop = 1'b1;
    step(4'b0001);
    for (int c = 0; c < 20; c++) step('0);
    chk("lb_echo_missing", int'(loop_err), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
